// File: rtl/ir_nec_pkg.sv
// Shared types and constants for the NEC infrared receiver.
package ir_nec_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        StIdle,
        StLeadL,
        StLeadH,
        StBitL,
        StBitH
    } nec_state_e;

    // Width counter is 14 bits and saturates at its maximum (16383 us)
    localparam int unsigned WidthW = 14;

    // Nominal phase widths in microseconds
    localparam int unsigned LeadLowUs    = 9000;
    localparam int unsigned LeadHighUs   = 4500;
    localparam int unsigned RepeatHighUs = 2250;
    localparam int unsigned BitLowUs     = 560;
    localparam int unsigned Bit0HighUs   = 560;
    localparam int unsigned Bit1HighUs   = 1690;

    // True when width lies inside [nom*(100-tol)/100, nom*(100+tol)/100]
    function automatic logic in_win(input logic [WidthW-1:0] width,
                                    input int unsigned       nom,
                                    input int unsigned       tol);
        logic [WidthW-1:0] lo;
        logic [WidthW-1:0] hi;
        lo = WidthW'(nom * (100 - tol) / 100);
        hi = WidthW'(nom * (100 + tol) / 100);
        return (width >= lo) && (width <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronises the raw IR line, detects edges and measures each phase in microseconds.
// rise_o/fall_o pulse one cycle after the synchronised edge; width_o holds the length of the
// phase that just ended. sat_o is high while the running counter sits at its maximum.
module ir_pulse_timer
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              iIR,
    output logic              rise_o,
    output logic              fall_o,
    output logic [WidthW-1:0] width_o,
    output logic              sat_o
);

    localparam int unsigned Div  = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;
    logic                   edge_det;
    logic                   tick;
    logic [PreW-1:0]        pre_q;
    logic [WidthW-1:0]      cnt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [WidthW-1:0]      width_q;

    assign level    = sync_q[SYNC_STAGES-1];
    assign edge_det = level ^ prev_q;
    assign tick     = (pre_q == PreW'(Div - 1)) && !edge_det;

    // Synchroniser and previous-level register; reset to idle-high so reset makes no edge
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iIR};
            prev_q <= level;
        end
    end

    // 1 us prescaler and saturating width counter, both restarted on every edge
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (edge_det) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= (pre_q == PreW'(Div - 1)) ? '0 : pre_q + 1'b1;
            if (tick && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Registered edge strobes with the width of the phase that just ended
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            width_q <= '0;
        end else begin
            rise_q <= edge_det & level;
            fall_q <= edge_det & ~level;
            if (edge_det) begin
                width_q <= cnt_q;
            end
        end
    end

    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign width_o = width_q;
    assign sat_o   = (cnt_q == '1);

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame receiver: lead-in check, LSB-first bit decode, data/inverse validation.
// Optional feature macro: IR_REPEAT_EN (recognise NEC repeat codes on Repeat_Flag).
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TOL_PCT     = 20,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              iIR,
    output logic [ADDR_W-1:0] irAddr,
    output logic [DATA_W-1:0] irData,
    output logic              Get_Flag,
    output logic              Err_Flag,
    output logic              Repeat_Flag
);

    localparam int unsigned FrameBits = ADDR_W + 2 * DATA_W;
    localparam int unsigned CntW      = $clog2(FrameBits + 1);

    logic              rise;
    logic              fall;
    logic              sat;
    logic [WidthW-1:0] width;

    nec_state_e           state_q, state_d;
    logic [CntW-1:0]      bits_q, bits_d;
    logic [FrameBits-1:0] sr_q, sr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 get_q, get_d;
    logic                 err_q, err_d;
`ifdef IR_REPEAT_EN
    logic                 rep_q, rep_d;
    logic                 have_q, have_d;
`endif

    ir_pulse_timer #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_timer (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .iIR     (iIR),
        .rise_o  (rise),
        .fall_o  (fall),
        .width_o (width),
        .sat_o   (sat)
    );

    // Next-state logic: phase width classification, bit shifting and frame completion
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        get_d   = 1'b0;
        err_d   = 1'b0;
`ifdef IR_REPEAT_EN
        rep_d   = 1'b0;
        have_d  = have_q;
`endif
        if ((state_q != StIdle) && sat) begin
            // Line stuck mid-frame
            err_d   = 1'b1;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fall) state_d = StLeadL;
                end
                StLeadL: begin
                    // A short or long first low is treated as noise, no flag
                    if (rise) state_d = in_win(width, LeadLowUs, TOL_PCT) ? StLeadH : StIdle;
                end
                StLeadH: begin
                    if (fall) begin
                        state_d = StIdle;
                        if (in_win(width, LeadHighUs, TOL_PCT)) begin
                            state_d = StBitL;
                            bits_d  = '0;
                        end else if (in_win(width, RepeatHighUs, TOL_PCT)) begin
`ifdef IR_REPEAT_EN
                            rep_d = have_q;
`else
                            err_d = 1'b1;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StBitL: begin
                    if (rise) begin
                        if (in_win(width, BitLowUs, TOL_PCT)) begin
                            state_d = StBitH;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StBitH: begin
                    if (fall) begin
                        if (in_win(width, Bit0HighUs, TOL_PCT) ||
                            in_win(width, Bit1HighUs, TOL_PCT)) begin
                            // LSB-first: new bit enters at the top and walks down
                            sr_d   = {in_win(width, Bit1HighUs, TOL_PCT), sr_q[FrameBits-1:1]};
                            bits_d = bits_q + 1'b1;
                            if (bits_d == CntW'(FrameBits)) begin
                                state_d = StIdle;
                                if (sr_d[ADDR_W +: DATA_W] == ~sr_d[ADDR_W+DATA_W +: DATA_W]) begin
                                    addr_d = sr_d[ADDR_W-1:0];
                                    data_d = sr_d[ADDR_W +: DATA_W];
                                    get_d  = 1'b1;
`ifdef IR_REPEAT_EN
                                    have_d = 1'b1;
`endif
                                end else begin
                                    err_d = 1'b1;
                                end
                            end else begin
                                state_d = StBitL;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, shift register, result and flag registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            bits_q  <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            get_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef IR_REPEAT_EN
            rep_q   <= 1'b0;
            have_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            get_q   <= get_d;
            err_q   <= err_d;
`ifdef IR_REPEAT_EN
            rep_q   <= rep_d;
            have_q  <= have_d;
`endif
        end
    end

    assign irAddr   = addr_q;
    assign irData   = data_q;
    assign Get_Flag = get_q;
    assign Err_Flag = err_q;
`ifdef IR_REPEAT_EN
    assign Repeat_Flag = rep_q;
`else
    assign Repeat_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_rx.sv
// Self-checking bench for ir_nec_rx: table-driven frames, repeat/reset sequences, random frames.
module tb_ir_nec_rx;

    localparam int ClkHz      = 2_000_000;
    localparam int CyclesPerUs = ClkHz / 1_000_000;
    localparam int Tol        = 20;
    localparam int AW         = 16;
    localparam int DW         = 8;
    localparam int SS         = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ir    = 1'b1;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          get;
    logic          err;
    logic          rep;

    int checks = 0;
    int errors = 0;

    ir_nec_rx #(
        .CLK_FREQ_HZ (ClkHz),
        .TOL_PCT     (Tol),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .iIR         (ir),
        .irAddr      (addr),
        .irData      (data),
        .Get_Flag    (get),
        .Err_Flag    (err),
        .Repeat_Flag (rep)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flag monitor, sampled on the falling clock edge
    int n_get = 0, n_err = 0, n_rep = 0, n_multi = 0, last_get_cyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (get) begin
                n_get = n_get + 1;
                last_get_cyc = cyc;
            end
            if (err) n_err = n_err + 1;
            if (rep) n_rep = n_rep + 1;
            if (int'(get) + int'(err) + int'(rep) > 1) n_multi = n_multi + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int jit_us(input int t, input int pct);
        int r;
        if (pct == 0) return t;
        r = int'($urandom_range(2 * pct, 0)) - pct;
        return t + t * r / 100;
    endfunction

    function automatic logic in_win(input int w, input int nom);
        return (w >= nom * (100 - Tol) / 100) && (w <= nom * (100 + Tol) / 100);
    endfunction

    task automatic phase(input logic lvl, input int us);
        ir = lvl;
        repeat (us * CyclesPerUs) @(negedge clk);
    endtask

    int stop_cyc = 0;

    // One NEC frame; bad_bit gets a high phase of bad_us, rst_bit gets a reset pulse in its low
    task automatic send_frame(input logic [15:0] a, input logic [7:0] c, input logic [7:0] inv,
                              input int bad_bit, input int bad_us, input int rst_bit,
                              input int jit);
        logic [31:0] bits;
        bits = {inv, c, a};
        phase(1'b0, jit_us(9000, jit));
        phase(1'b1, jit_us(4500, jit));
        for (int i = 0; i < 32; i++) begin
            if (i == rst_bit) begin
                ir = 1'b0;
                repeat (20) @(negedge clk);
                rst_n = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
                phase(1'b0, 500);
            end else begin
                phase(1'b0, jit_us(560, jit));
            end
            if (i == bad_bit) phase(1'b1, bad_us);
            else phase(1'b1, jit_us(bits[i] ? 1690 : 560, jit));
        end
        stop_cyc = cyc;
        phase(1'b0, 560);
        phase(1'b1, 300);
    endtask

    task automatic send_repeat();
        phase(1'b0, 9000);
        phase(1'b1, 2250);
        phase(1'b0, 560);
        phase(1'b1, 300);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  c;
        logic [7:0]  inv;
        int          bad_bit;
        int          bad_us;
        int          exp_get;
        int          exp_err;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[5];
    int g0, e0, r0;

    task automatic snap();
        g0 = n_get;
        e0 = n_err;
        r0 = n_rep;
    endtask

    task automatic run_vec(input int i);
        snap();
        send_frame(vecs[i].a, vecs[i].c, vecs[i].inv, vecs[i].bad_bit, vecs[i].bad_us, -1, 0);
        check($sformatf("v%0d_get", i), n_get - g0, vecs[i].exp_get);
        check($sformatf("v%0d_err", i), n_err - e0, vecs[i].exp_err);
        check($sformatf("v%0d_rep", i), n_rep - r0, 0);
        check($sformatf("v%0d_addr", i), int'(addr), int'(vecs[i].exp_addr));
        check($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_data));
    endtask

    logic [15:0] m_addr;
    logic [7:0]  m_data;

    initial begin
        vecs[0] = '{16'h0001, 8'h12, 8'hED, -1, 0,    1, 0, 16'h0001, 8'h12};
        vecs[1] = '{16'h0002, 8'hEB, 8'h14, -1, 0,    1, 0, 16'h0002, 8'hEB};
        vecs[2] = '{16'h0004, 8'h34, 8'hCC, -1, 0,    0, 1, 16'h0002, 8'hEB};
        vecs[3] = '{16'h0005, 8'h66, 8'h99, 0,  3000, 0, 1, 16'h0002, 8'hEB};
        vecs[4] = '{16'h0003, 8'h55, 8'hAA, -1, 0,    1, 0, 16'h0003, 8'h55};

        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_addr", int'(addr), 0);
        check("rst_data", int'(data), 0);
        check("rst_get", int'(get), 0);
        check("rst_err", int'(err), 0);
        check("rst_rep", int'(rep), 0);
        phase(1'b1, 100);

        // Repeat code before any good frame
        snap();
        send_repeat();
        check("early_rep", n_rep - r0, 0);
`ifdef IR_REPEAT_EN
        check("early_rep_err", n_err - e0, 0);
`else
        check("early_rep_err", n_err - e0, 1);
`endif

        run_vec(0);
        check("get_latency", last_get_cyc - stop_cyc, SS + 2);
        run_vec(1);
        run_vec(2);

        // Repeat code after a good frame
        snap();
        send_repeat();
`ifdef IR_REPEAT_EN
        check("rep_flag", n_rep - r0, 1);
        check("rep_err", n_err - e0, 0);
`else
        check("rep_flag", n_rep - r0, 0);
        check("rep_err", n_err - e0, 1);
`endif
        check("rep_get", n_get - g0, 0);
        check("rep_addr", int'(addr), 16'h0002);
        check("rep_data", int'(data), 8'hEB);

        run_vec(3);
        run_vec(4);

        // Reset during bit 10, then a clean frame
        snap();
        send_frame(16'h0006, 8'h77, 8'h88, -1, 0, 10, 0);
        check("midrst_flags", (n_get - g0) + (n_err - e0) + (n_rep - r0), 0);
        check("midrst_addr", int'(addr), 0);
        check("midrst_data", int'(data), 0);
        snap();
        send_frame(16'h0007, 8'h21, 8'hDE, -1, 0, -1, 0);
        check("after_rst_get", n_get - g0, 1);
        check("after_rst_addr", int'(addr), 16'h0007);
        check("after_rst_data", int'(data), 8'h21);

        // Random frames against a width-classifying reference model
        m_addr = 16'h0007;
        m_data = 8'h21;
        for (int n = 0; n < 3; n++) begin
            logic [15:0] a;
            logic [7:0]  c, inv;
            logic [31:0] bits, dec;
            int          mode, bb, bus, w, eg, ee;
            logic        ok;
            a = 16'($urandom);
            c = 8'($urandom);
            inv = ~c;
            bb = -1;
            bus = 0;
            mode = int'($urandom_range(2, 0));
            if (mode == 1) inv = ~c ^ 8'($urandom_range(255, 1));
            bits = {inv, c, a};
            if (mode == 2) begin
                bb = int'($urandom_range(31, 0));
                bus = (bits[bb] ? 1690 : 560) * 3 / 2;
            end
            ok = 1'b1;
            dec = '0;
            for (int i = 0; i < 32; i++) begin
                w = (i == bb) ? bus : (bits[i] ? 1690 : 560);
                if (in_win(w, 560)) dec[i] = 1'b0;
                else if (in_win(w, 1690)) dec[i] = 1'b1;
                else ok = 1'b0;
            end
            eg = (ok && (dec[23:16] == ~dec[31:24])) ? 1 : 0;
            ee = 1 - eg;
            if (eg == 1) begin
                m_addr = dec[15:0];
                m_data = dec[23:16];
            end
            snap();
            send_frame(a, c, inv, bb, bus, -1, 8);
            check($sformatf("rnd%0d_get", n), n_get - g0, eg);
            check($sformatf("rnd%0d_err", n), n_err - e0, ee);
            check($sformatf("rnd%0d_addr", n), int'(addr), int'(m_addr));
            check($sformatf("rnd%0d_data", n), int'(data), int'(m_data));
        end

        check("flag_exclusive", n_multi, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
